// File: rtl/player_controller.sv
// One fighter's position/action state machine, advanced once per frame_tick.
// Optional macro INPUT_SYNC_EN adds a 2-flop synchronizer on the btn_* and hit_in inputs.
`timescale 1ns/1ps
module player_controller #(
    parameter int START_X         = 20,
    parameter int GROUND_Y        = 400,
    parameter int MIN_X           = 0,
    parameter int MAX_X           = 600,
    parameter int SPEED           = 4,
    parameter int JUMP_V          = 12,
    parameter int GRAVITY         = 1,
    parameter int ATTACK_FRAMES   = 10,
    parameter int COOLDOWN_FRAMES = 15,
    parameter int HIT_FRAMES      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_attack,
    input  logic       btn_block,
    input  logic       hit_in,
    output logic [9:0] p_x,
    output logic [9:0] p_y,
    output logic [1:0] p_state,
    output logic       grounded
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ATTACK = 2'd1,
        BLOCK  = 2'd2,
        HIT    = 2'd3
    } state_t;

    localparam logic [10:0]        MIN_X_W  = 11'(MIN_X);
    localparam logic [10:0]        MAX_X_W  = 11'(MAX_X);
    localparam logic [10:0]        SPEED_W  = 11'(SPEED);
    localparam logic signed [11:0] GROUND_S = 12'(GROUND_Y);

    logic [5:0] raw_in;
    logic [5:0] in_sync;
    assign raw_in = {hit_in, btn_block, btn_attack, btn_jump, btn_right, btn_left};

`ifdef INPUT_SYNC_EN
    logic [5:0] sync1_reg;
    logic [5:0] sync2_reg;
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                end else begin
                    sync1_reg[gi] <= raw_in[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate
    assign in_sync = sync2_reg;
`else
    assign in_sync = raw_in;
`endif

    logic left, right, jump, attack, block, hit;
    assign {hit, block, attack, jump, right, left} = in_sync;

    logic [9:0]        x_reg, x_next;
    logic [9:0]        y_reg, y_next;
    logic signed [7:0] vy_reg, vy_next;
    state_t            state_reg, state_next;
    logic [7:0]        timer_reg, timer_next;
    logic [7:0]        cooldown_reg, cooldown_next;

    logic              jump_start;
    logic signed [7:0] vy_cur;
    logic signed [11:0] y_calc;
    logic [10:0]       x_wide;

    assign x_wide   = {1'b0, x_reg};
    assign grounded = (y_reg == 10'(GROUND_Y)) && (vy_reg == 8'sd0);

    always_comb begin
        x_next        = x_reg;
        y_next        = y_reg;
        vy_next       = vy_reg;
        state_next    = state_reg;
        timer_next    = timer_reg;
        cooldown_next = cooldown_reg;
        jump_start    = 1'b0;
        vy_cur        = vy_reg;
        y_calc        = '0;

        if (frame_tick) begin
            if (state_reg == IDLE) begin
                if (left && !right)
                    x_next = (x_wide < MIN_X_W + SPEED_W) ? 10'(MIN_X) : 10'(x_wide - SPEED_W);
                else if (right && !left)
                    x_next = (x_wide + SPEED_W > MAX_X_W) ? 10'(MAX_X) : 10'(x_wide + SPEED_W);
            end

            // Jump start behaves like an airborne tick with vy preloaded to JUMP_V.
            jump_start = grounded && jump && (state_reg == IDLE);
            vy_cur     = jump_start ? 8'(JUMP_V) : vy_reg;
            if (jump_start || !grounded) begin
                y_calc = $signed({2'b00, y_reg}) - {{4{vy_cur[7]}}, vy_cur};
                if (y_calc >= GROUND_S) begin
                    y_next  = 10'(GROUND_Y);
                    vy_next = 8'sd0;
                end else begin
                    y_next  = y_calc[9:0];
                    vy_next = vy_cur - 8'(GRAVITY);
                end
            end

            if (cooldown_reg != 8'd0)
                cooldown_next = cooldown_reg - 8'd1;

            case (state_reg)
                IDLE: begin
                    if (attack && cooldown_reg == 8'd0) begin
                        state_next = ATTACK;
                        timer_next = 8'(ATTACK_FRAMES);
                    end else if (block && grounded) begin
                        state_next = BLOCK;
                    end
                end
                ATTACK: begin
                    if (timer_reg == 8'd1) begin
                        state_next    = IDLE;
                        timer_next    = 8'd0;
                        cooldown_next = 8'(COOLDOWN_FRAMES);
                    end else begin
                        timer_next = timer_reg - 8'd1;
                    end
                end
                BLOCK: begin
                    if (!block)
                        state_next = IDLE;
                end
                HIT: begin
                    if (timer_reg == 8'd1) begin
                        state_next = IDLE;
                        timer_next = 8'd0;
                    end else begin
                        timer_next = timer_reg - 8'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        // A connecting hit overrides any button-driven transition, on or off a tick.
        if (hit && (state_reg == IDLE || state_reg == ATTACK)) begin
            state_next = HIT;
            timer_next = 8'(HIT_FRAMES);
            if (state_reg == ATTACK)
                cooldown_next = 8'(COOLDOWN_FRAMES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg        <= 10'(START_X);
            y_reg        <= 10'(GROUND_Y);
            vy_reg       <= 8'sd0;
            state_reg    <= IDLE;
            timer_reg    <= 8'd0;
            cooldown_reg <= 8'd0;
        end else begin
            x_reg        <= x_next;
            y_reg        <= y_next;
            vy_reg       <= vy_next;
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            cooldown_reg <= cooldown_next;
        end
    end

    assign p_x     = x_reg;
    assign p_y     = y_reg;
    assign p_state = state_reg;

endmodule
